// File: rtl/sha256_block_feeder.sv
// sha256_block_feeder
//   Streams one message of NUM_OF_WORDS 32-bit words out of a word-addressed
//   memory and appends SHA-256 padding (0x80000000 marker, zero fill, 32-bit
//   bit length in the last word), presenting BLOCKS*16 words to a compression
//   core over a valid/ready handshake.
//
// Ports
//   clk              rising-edge clock
//   reset_n          synchronous active-low reset
//   i_start          begin a message (sampled only while idle)
//   i_message_addr   base word address of the message
//   o_mem_addr       memory read address (holds its value between reads)
//   o_mem_re         memory read strobe, data returns one cycle later
//   i_mem_read_data  memory read data
//   o_w_valid        o_w_data holds a schedule word
//   i_w_ready        downstream accepts the word
//   o_w_data         padded message word
//   o_w_idx          word position within its 16-word block
//   o_w_last_block   word belongs to the final block
//   o_busy           high from start acceptance through the done cycle
//   o_done           one-cycle pulse after the final word is accepted
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for i_start
// RD     | read strobe for message word i
// LAT    | memory latency cycle, read data captured into w_data
// OUT    | word i presented, waiting for acceptance
// FIN    | done pulse, back to IDLE next cycle

module sha256_block_feeder #(
  parameter int NUM_OF_WORDS = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic [15:0] i_message_addr,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_re,
  input  logic [31:0] i_mem_read_data,
  output logic        o_w_valid,
  input  logic        i_w_ready,
  output logic [31:0] o_w_data,
  output logic [3:0]  o_w_idx,
  output logic        o_w_last_block,
  output logic        o_busy,
  output logic        o_done
);

  localparam int BLOCKS = ((NUM_OF_WORDS + 2) / 16) + 1;
  localparam int TOTAL  = BLOCKS * 16;
  // Up to 120 words gives at most 128 emitted words, so 8 bits suffice.
  localparam int IW     = 8;

  localparam logic [IW-1:0] LAST_I     = IW'(TOTAL - 1);
  localparam logic [IW-1:0] MSG_END    = IW'(NUM_OF_WORDS);
  localparam logic [IW-1:0] LAST_BLK_I = IW'(TOTAL - 16);
  localparam logic [31:0]   LEN_BITS   = 32'(NUM_OF_WORDS * 32);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAT,
    S_OUT,
    S_FIN
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [IW-1:0]  r_i;
  logic [IW-1:0]  w_i_next;
  logic [IW-1:0]  w_i_inc;
  logic [15:0]    r_base;
  logic [15:0]    w_base_next;
  logic [15:0]    r_mem_addr;
  logic [15:0]    w_mem_addr_next;
  logic [31:0]    r_w_data;
  logic [31:0]    w_data_next;

  function automatic logic [31:0] pad_word(input logic [IW-1:0] idx);
    if (idx == MSG_END) begin
      return 32'h8000_0000;
    end else if (idx == LAST_I) begin
      return LEN_BITS;
    end else begin
      return 32'h0000_0000;
    end
  endfunction

  assign w_i_inc = r_i + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_i        <= '0;
      r_base     <= '0;
      r_mem_addr <= '0;
      r_w_data   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_i        <= w_i_next;
      r_base     <= w_base_next;
      r_mem_addr <= w_mem_addr_next;
      r_w_data   <= w_data_next;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_i_next        = r_i;
    w_base_next     = r_base;
    w_mem_addr_next = r_mem_addr;
    w_data_next     = r_w_data;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          // NUM_OF_WORDS >= 1, so word 0 is always a memory word.
          w_base_next     = i_message_addr;
          w_i_next        = '0;
          w_mem_addr_next = i_message_addr;
          w_next_state    = S_RD;
        end
      end
      S_RD: begin
        w_next_state = S_LAT;
      end
      S_LAT: begin
        w_data_next  = i_mem_read_data;
        w_next_state = S_OUT;
      end
      S_OUT: begin
        if (i_w_ready) begin
          if (r_i == LAST_I) begin
            w_next_state = S_FIN;
          end else begin
            w_i_next = w_i_inc;
            if (w_i_inc < MSG_END) begin
              // 16-bit add wraps past 16'hFFFF by construction.
              w_mem_addr_next = r_base + 16'(w_i_inc);
              w_next_state    = S_RD;
            end else begin
              w_data_next  = pad_word(w_i_inc);
              w_next_state = S_OUT;
            end
          end
        end
      end
      S_FIN: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Outputs are gated by reset_n so they read as zero for the whole reset
  // window, not only after the first reset edge.
  assign o_mem_re       = reset_n && (r_state == S_RD);
  assign o_mem_addr     = reset_n ? r_mem_addr : 16'h0000;
  assign o_w_valid      = reset_n && (r_state == S_OUT);
  assign o_w_data       = r_w_data;
  assign o_w_idx        = o_w_valid ? r_i[3:0] : 4'h0;
  assign o_w_last_block = o_w_valid && (r_i >= LAST_BLK_I);
  assign o_busy         = reset_n && (r_state != S_IDLE);
  assign o_done         = reset_n && (r_state == S_FIN);

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Bench for sha256_block_feeder: three instances (30, 13 and 14 words) share
// clock, reset and ready; each streams against a behavioural padding model.
module tb_sha256_block_feeder;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             w_ready = 1'b1;
  logic [15:0]      message_addr = 16'h0000;
  logic [2:0]       start = 3'b000;
  logic [2:0]       mem_re, w_valid, w_last_block, busy, done;
  logic [2:0][15:0] mem_addr;
  logic [2:0][31:0] rd_data;
  logic [2:0][31:0] w_data;
  logic [2:0][3:0]  w_idx;

  bit               rand_bp = 1'b0;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cfg_n [3] = '{30, 13, 14};
  logic [15:0]      cur_base [3] = '{16'h0, 16'h0, 16'h0};
  int               cnt_acc [3] = '{0, 0, 0};
  int               cnt_rd [3] = '{0, 0, 0};
  int               cnt_done [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  sha256_block_feeder #(.NUM_OF_WORDS(30)) u_dut30 (
    .clk(clk), .reset_n(reset_n), .i_start(start[0]), .i_message_addr(message_addr),
    .o_mem_addr(mem_addr[0]), .o_mem_re(mem_re[0]), .i_mem_read_data(rd_data[0]),
    .o_w_valid(w_valid[0]), .i_w_ready(w_ready), .o_w_data(w_data[0]), .o_w_idx(w_idx[0]),
    .o_w_last_block(w_last_block[0]), .o_busy(busy[0]), .o_done(done[0]));

  sha256_block_feeder #(.NUM_OF_WORDS(13)) u_dut13 (
    .clk(clk), .reset_n(reset_n), .i_start(start[1]), .i_message_addr(message_addr),
    .o_mem_addr(mem_addr[1]), .o_mem_re(mem_re[1]), .i_mem_read_data(rd_data[1]),
    .o_w_valid(w_valid[1]), .i_w_ready(w_ready), .o_w_data(w_data[1]), .o_w_idx(w_idx[1]),
    .o_w_last_block(w_last_block[1]), .o_busy(busy[1]), .o_done(done[1]));

  sha256_block_feeder #(.NUM_OF_WORDS(14)) u_dut14 (
    .clk(clk), .reset_n(reset_n), .i_start(start[2]), .i_message_addr(message_addr),
    .o_mem_addr(mem_addr[2]), .o_mem_re(mem_re[2]), .i_mem_read_data(rd_data[2]),
    .o_w_valid(w_valid[2]), .i_w_ready(w_ready), .o_w_data(w_data[2]), .o_w_idx(w_idx[2]),
    .o_w_last_block(w_last_block[2]), .o_busy(busy[2]), .o_done(done[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: rotl(0x01234675, addr mod 32).
  function automatic logic [31:0] memf(input logic [15:0] a);
    logic [31:0] c;
    int          s;
    c = 32'h0123_4675;
    s = int'(a[4:0]);
    return (c << s) | (c >> (32 - s));
  endfunction

  // SHA-256: message bits + 1 marker bit + 64 length bits, rounded up to 512.
  function automatic int nblocks(input int n);
    return (n * 32 + 65 + 511) / 512;
  endfunction

  function automatic logic [31:0] expw(input int n, input logic [15:0] base, input int k);
    int total;
    total = nblocks(n) * 16;
    if (k < n) return memf(16'(base + 16'(k)));
    if (k == n) return 32'h8000_0000;
    if (k == total - 1) return 32'(n * 32);
    return 32'h0;
  endfunction

  // Memory: data valid one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (mem_re[d]) rd_data[d] <= memf(mem_addr[d]);
      else           rd_data[d] <= $urandom;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 w_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Every presented word (stalled or not) is compared with the model word
  // for the next acceptance index.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int d = 0; d < 3; d++) begin
        if (w_valid[d]) begin
          check("w_data", w_data[d], expw(cfg_n[d], cur_base[d], cnt_acc[d]));
          check("w_idx", 32'(w_idx[d]), 32'(cnt_acc[d] % 16));
          check("w_last_block", 32'(w_last_block[d]),
                32'((cnt_acc[d] / 16) == nblocks(cfg_n[d]) - 1));
          if (w_ready) cnt_acc[d]++;
        end
        if (mem_re[d]) begin
          check("mem_addr", 32'(mem_addr[d]), 32'(16'(cur_base[d] + 16'(cnt_rd[d]))));
          check("re_during_out", 32'(w_valid[d]), 32'h0);
          cnt_rd[d]++;
        end
        if (done[d]) begin
          cnt_done[d]++;
          check("acc_at_done", cnt_acc[d], 32'(nblocks(cfg_n[d]) * 16));
        end
      end
    end
  end

  task automatic clear_counts(input int d);
    cnt_acc[d]  = 0;
    cnt_rd[d]   = 0;
    cnt_done[d] = 0;
  endtask

  task automatic check_quiet_outputs();
    for (int d = 0; d < 3; d++) begin
      check("rst_busy", 32'(busy[d]), 32'h0);
      check("rst_valid", 32'(w_valid[d]), 32'h0);
      check("rst_mem_re", 32'(mem_re[d]), 32'h0);
      check("rst_done", 32'(done[d]), 32'h0);
      check("rst_mem_addr", 32'(mem_addr[d]), 32'h0);
      check("rst_idx", 32'(w_idx[d]), 32'h0);
      check("rst_last", 32'(w_last_block[d]), 32'h0);
    end
  endtask

  task automatic start_msg(input int d, input logic [15:0] base, input bit hold);
    @(posedge clk);
    #1;
    clear_counts(d);
    cur_base[d]  = base;
    message_addr = base;
    start[d]     = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input bit poke);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (poke && c == 6) begin
        start[d]     = 1'b1;
        message_addr = 16'($urandom);
      end
      if (poke && c == 7) begin
        start[d]     = 1'b0;
        message_addr = cur_base[d];
      end
      if (done[d]) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'h1);
  endtask

  task automatic finish_msg(input int d);
    @(posedge clk);
    #1;
    check("words_emitted", cnt_acc[d], 32'(nblocks(cfg_n[d]) * 16));
    check("reads_issued", cnt_rd[d], 32'(cfg_n[d]));
    check("done_pulses", cnt_done[d], 32'h1);
    @(negedge clk);
    check("busy_fall", 32'(busy[d]), 32'h0);
    check("done_single", 32'(done[d]), 32'h0);
  endtask

  task automatic run_msg(input int d, input logic [15:0] base, input bit poke);
    start_msg(d, base, 1'b0);
    wait_done(d, poke);
    finish_msg(d);
  endtask

  initial begin
    bit reached;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet_outputs();
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Full-rate streaming on all three lengths.
    rand_bp = 1'b0;
    run_msg(0, 16'h0000, 1'b0);
    run_msg(1, 16'($urandom), 1'b0);
    run_msg(2, 16'($urandom), 1'b0);

    // Random backpressure, address wrap, and ignored starts while busy.
    rand_bp = 1'b1;
    run_msg(0, 16'h0000, 1'b1);
    run_msg(0, 16'hFFF0, 1'b1);
    run_msg(1, 16'($urandom), 1'b1);
    run_msg(2, 16'($urandom), 1'b1);
    for (int r = 0; r < 4; r++) begin
      run_msg(int'($urandom_range(0, 2)), 16'($urandom), 1'b1);
    end

    // start held across FIN: idle one cycle, then restart from IDLE.
    start_msg(0, 16'h1234, 1'b1);
    wait_done(0, 1'b0);
    @(posedge clk);
    #1 clear_counts(0);
    @(negedge clk);
    check("hold_busy_gap", 32'(busy[0]), 32'h0);
    @(negedge clk);
    check("hold_restart", 32'(busy[0]), 32'h1);
    start[0] = 1'b0;

    // Abandon the restarted message after word 20 is accepted.
    reached = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (cnt_acc[0] >= 21) begin
        reached = 1'b1;
        break;
      end
    end
    check("reach_word20", 32'(reached), 32'h1);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet_outputs();
    check("no_done_on_abort", cnt_done[0], 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    run_msg(0, 16'hBEEF, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
